// File: rtl/system_top_sdiv_30s_16s_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// dout_rem exists only when SDIV_REMAINDER_EN is defined.
interface system_top_sdiv_30s_16s_seq_if #(
    parameter int din0_WIDTH = 30,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 30
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
`ifdef SDIV_REMAINDER_EN
    logic [din1_WIDTH-1:0] dout_rem;
`endif
    logic                  div_by_zero;
    logic                  ovf;

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout,
`ifdef SDIV_REMAINDER_EN
        output dout_rem,
`endif
        output div_by_zero, ovf
    );

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout,
`ifdef SDIV_REMAINDER_EN
        input  dout_rem,
`endif
        input  div_by_zero, ovf
    );
endinterface

// File: rtl/system_top_sdiv_30s_16s_seq.sv
// Radix-2 restoring signed divider, 30s / 16s -> 30s, one quotient bit per cycle.
// Optional remainder output enabled by defining SDIV_REMAINDER_EN.
module system_top_sdiv_30s_16s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 30,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 30
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst_n,
    system_top_sdiv_30s_16s_seq_if.slave         bus
);
    localparam int CW = $clog2(din0_WIDTH);

    localparam logic [din0_WIDTH-1:0] DIN0_MIN = {1'b1, {(din0_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] Q_MAX    = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] Q_MIN    = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [din0_WIDTH-1:0] dq;        // dividend magnitude shifts out the top, quotient shifts in the bottom
    logic [din1_WIDTH-1:0] dvs;
    logic [din1_WIDTH:0]   rem;
    logic                  sign_q;
    logic                  sign_r;
    logic                  is_dz;
    logic                  is_ovf;
    logic                  fix_stage;
    logic [dout_WIDTH-1:0] q_fix;
`ifdef SDIV_REMAINDER_EN
    logic [din1_WIDTH-1:0] din0_lo;
    logic [din1_WIDTH-1:0] r_fix;
`endif

    logic [din0_WIDTH-1:0] din0_mag;
    logic [din1_WIDTH-1:0] din1_mag;
    logic [din1_WIDTH+1:0] trial;
    logic [din1_WIDTH+1:0] diff;

    // Unsigned magnitudes of the operand width already hold 2^(W-1), so the
    // most negative dividend and divisor need no extra bit here.
    always_comb begin
        din0_mag = bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
        din1_mag = bus.din1[din1_WIDTH-1] ? -bus.din1 : bus.din1;
        trial    = {rem, dq[din0_WIDTH-1]};
        diff     = trial - {2'b00, dvs};
    end

    // NOTE: every register here is a plain flop with a reset value and all
    // updates are nonblocking, so state and outputs move together on the edge.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            dq              <= '0;
            dvs             <= '0;
            rem             <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            is_dz           <= 1'b0;
            is_ovf          <= 1'b0;
            fix_stage       <= 1'b0;
            q_fix           <= '0;
`ifdef SDIV_REMAINDER_EN
            din0_lo         <= '0;
            r_fix           <= '0;
            bus.dout_rem    <= '0;
`endif
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.dout        <= '0;
            bus.div_by_zero <= 1'b0;
            bus.ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dq           <= din0_mag;
                        dvs          <= din1_mag;
                        rem          <= '0;
                        sign_q       <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
                        sign_r       <= bus.din0[din0_WIDTH-1];
                        is_dz        <= (bus.din1 == '0);
                        is_ovf       <= (bus.din0 == DIN0_MIN) && (bus.din1 == '1);
`ifdef SDIV_REMAINDER_EN
                        din0_lo      <= bus.din0[din1_WIDTH-1:0];
`endif
                        cnt          <= CW'(din0_WIDTH - 1);
                        fix_stage    <= 1'b0;
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end

                CALC: begin
                    // Negative trial difference means restore (keep the shifted remainder).
                    dq  <= {dq[din0_WIDTH-2:0], ~diff[din1_WIDTH+1]};
                    rem <= diff[din1_WIDTH+1] ? trial[din1_WIDTH:0] : diff[din1_WIDTH:0];
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                FIX: begin
                    // Stage 0 applies signs and special cases, stage 1 publishes;
                    // this keeps the negation off the output flops and the
                    // latency at din0_WIDTH+2 edges regardless of operands.
                    if (!fix_stage) begin
                        if (is_ovf) begin
                            q_fix <= Q_MAX;
                        end else if (is_dz) begin
                            q_fix <= sign_r ? Q_MIN : Q_MAX;
                        end else begin
                            q_fix <= sign_q ? -dq : dq;
                        end
`ifdef SDIV_REMAINDER_EN
                        if (is_ovf) begin
                            r_fix <= '0;
                        end else if (is_dz) begin
                            r_fix <= din0_lo;
                        end else begin
                            r_fix <= sign_r ? -rem[din1_WIDTH-1:0] : rem[din1_WIDTH-1:0];
                        end
`endif
                        fix_stage <= 1'b1;
                    end else begin
                        bus.dout        <= q_fix;
`ifdef SDIV_REMAINDER_EN
                        bus.dout_rem    <= r_fix;
`endif
                        bus.div_by_zero <= is_dz;
                        bus.ovf         <= is_ovf;
                        bus.out_valid   <= 1'b1;
                        state           <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid   <= 1'b0;
                        bus.div_by_zero <= 1'b0;
                        bus.ovf         <= 1'b0;
                        bus.in_ready    <= 1'b1;
                        state           <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_system_top_sdiv_30s_16s_seq.sv
// Directed bench for the sequential signed divider: signs, divide-by-zero,
// overflow, backpressure and mid-operation reset.
module tb_system_top_sdiv_30s_16s_seq;
    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total    = 0;

    system_top_sdiv_30s_16s_seq_if bus ();

    system_top_sdiv_30s_16s_seq dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic launch(input string tag, input int a, input int b);
        check({tag, "_in_ready_before"}, 64'(bus.in_ready), 1);
        bus.din0     = 30'(a);
        bus.din1     = 16'(b);
        bus.in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 0);
    endtask

    task automatic wait_result(input string tag, input int eq, input int er,
                               input bit edz, input bit eovf);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 32);
        check({tag, "_dout"}, $signed(bus.dout), eq);
`ifdef SDIV_REMAINDER_EN
        check({tag, "_rem"}, $signed(bus.dout_rem), er);
`else
        if (er != er) $display("unreachable");
`endif
        check({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'(edz));
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(eovf));
    endtask

    task automatic run_op(input string tag, input int a, input int b, input int eq,
                          input int er, input bit edz, input bit eovf);
        launch(tag, a, b);
        wait_result(tag, eq, er, edz, eovf);
        @(posedge ap_clk);
        #1;
        check({tag, "_out_valid_cleared"}, 64'(bus.out_valid), 0);
        check({tag, "_in_ready_after"}, 64'(bus.in_ready), 1);
        check({tag, "_flags_cleared"}, 64'({bus.div_by_zero, bus.ovf}), 0);
    endtask

    initial begin
        int vcount;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.din0      = '0;
        bus.din1      = '0;

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_dout", $signed(bus.dout), 0);
        check("rst_flags", 64'({bus.div_by_zero, bus.ovf}), 0);
`ifdef SDIV_REMAINDER_EN
        check("rst_rem", $signed(bus.dout_rem), 0);
`endif
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Basic division and sign combinations
        run_op("p1000_7",   1000,  7,  142,  6, 1'b0, 1'b0);
        run_op("n1000_7",  -1000,  7, -142, -6, 1'b0, 1'b0);
        run_op("p1000_n7",  1000, -7, -142,  6, 1'b0, 1'b0);
        run_op("n1000_n7", -1000, -7,  142, -6, 1'b0, 1'b0);

        // Divide by zero
        run_op("p5_0",  5, 0,  536870911,  5, 1'b1, 1'b0);
        run_op("n5_0", -5, 0, -536870912, -5, 1'b1, 1'b0);

        // Overflow and extremes
        run_op("min_n1", -536870912, -1,  536870911, 0, 1'b0, 1'b1);
        run_op("min_p1", -536870912,  1, -536870912, 0, 1'b0, 1'b0);
        run_op("p100_max", 100, 32767, 0, 100, 1'b0, 1'b0);
        run_op("max_min", 536870911, -32768, -16383, 32767, 1'b0, 1'b0);

        // Backpressure: result held, new operands ignored
        bus.out_ready = 1'b0;
        launch("bp", 123456, -321);
        wait_result("bp", -384, 192, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.din0     = 30'd77;
            bus.din1     = 16'd1;
            @(posedge ap_clk);
            #1;
            check("bp_hold_dout", $signed(bus.dout), -384);
`ifdef SDIV_REMAINDER_EN
            check("bp_hold_rem", $signed(bus.dout_rem), 192);
`endif
            check("bp_hold_valid", 64'(bus.out_valid), 1);
            check("bp_hold_in_ready", 64'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_valid", 64'(bus.out_valid), 0);
        check("bp_release_in_ready", 64'(bus.in_ready), 1);

        // Reset in the middle of CALC discards the operation
        launch("rst_mid", 1000, 7);
        repeat (9) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        check("rst_mid_in_ready", 64'(bus.in_ready), 1);
        check("rst_mid_out_valid", 64'(bus.out_valid), 0);
        check("rst_mid_dout", $signed(bus.dout), 0);
        check("rst_mid_flags", 64'({bus.div_by_zero, bus.ovf}), 0);
`ifdef SDIV_REMAINDER_EN
        check("rst_mid_rem", $signed(bus.dout_rem), 0);
`endif
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk);
            #1;
            if (bus.out_valid) vcount++;
        end
        check("rst_mid_no_result", vcount, 0);
        run_op("p77_n7", 77, -7, -11, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
